mem_stage: RTL and testbench



---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_stage_bm_beat_buf.sv | 36 +++
 rtl/mem_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory stage and its bitmap beat buffer.
package mem_pkg;

    localparam int WORD_W   = 16;
    localparam int BM_WORDS = 96;
    localparam int BEAT_W   = 7;
    localparam int BM_W     = WORD_W * BM_WORDS;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WORD     = 2'd1,
        BURST_RD = 2'd2,
        BURST_WR = 2'd3
    } state_e;

    // Beat address wraps at 2^16 by construction of the 16-bit sum.
    function automatic logic [WORD_W-1:0] beat_addr(input logic [WORD_W-1:0] base,
                                                    input logic [BEAT_W-1:0] beat);
        return base + {9'd0, beat};
    endfunction

endpackage

// File: rtl/mem_stage_bm_beat_buf.sv
// Bitmap staging buffer: parallel load/read plus one 16-bit slice per beat.
module bm_beat_buf
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [BM_W-1:0]   load_data_i,
    input  logic              wr_i,
    input  logic [BEAT_W-1:0] beat_i,
    input  logic [WORD_W-1:0] wr_data_i,
    output logic [WORD_W-1:0] slice_o,
    output logic [BM_W-1:0]   data_o
);

    logic [BM_W-1:0] buf_q;
    logic [10:0]     lsb_s;

    assign lsb_s   = {beat_i, 4'd0};
    assign slice_o = buf_q[lsb_s +: WORD_W];
    assign data_o  = buf_q;

    // Buffer storage: a parallel load wins over a slice write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
        end else if (load_i) begin
            buf_q <= load_data_i;
        end else if (wr_i) begin
            buf_q[lsb_s +: WORD_W] <= wr_data_i;
        end else begin
            buf_q <= buf_q;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: word and 96-beat bitmap accesses over one req/ack port,
// with a registered writeback bundle and an upstream stall.
module mem_stage
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              ld,
    input  logic              st,
    input  logic              ldb,
    input  logic              stb,
    input  logic [WORD_W-1:0] rd_data,
    input  logic [WORD_W-1:0] st_data,
    input  logic [BM_W-1:0]   bd_data,
    input  logic [3:0]        rd_addr,
    input  logic [1:0]        bd_addr,
    input  logic              rd_we,
    input  logic              bd_we,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    output logic              wb_rd_we,
    output logic              wb_bd_we,
    output logic [3:0]        wb_rd_addr,
    output logic [1:0]        wb_bd_addr,
    output logic [WORD_W-1:0] wb_rd_data,
    output logic [BM_W-1:0]   wb_bd_data
);

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] st_data_q, st_data_d;
    logic [3:0]        rd_addr_q, rd_addr_d;
    logic [1:0]        bd_addr_q, bd_addr_d;
    logic              word_st_q, word_st_d;

    logic              wb_valid_q, wb_valid_d;
    logic              wb_rd_we_q, wb_rd_we_d;
    logic              wb_bd_we_q, wb_bd_we_d;
    logic [3:0]        wb_rd_addr_q, wb_rd_addr_d;
    logic [1:0]        wb_bd_addr_q, wb_bd_addr_d;
    logic [WORD_W-1:0] wb_rd_data_q, wb_rd_data_d;
    logic [BM_W-1:0]   wb_bd_data_q, wb_bd_data_d;

    logic              buf_load_s, buf_wr_s;
    logic [WORD_W-1:0] buf_slice_s;
    logic [BM_W-1:0]   buf_data_s;
    logic              any_mem_s, in_burst_s, last_beat_s, done_s;

    bm_beat_buf u_buf (
        .clk         (clk),
        .rst         (rst),
        .load_i      (buf_load_s),
        .load_data_i (bd_data),
        .wr_i        (buf_wr_s),
        .beat_i      (beat_q),
        .wr_data_i   (mem_rdata),
        .slice_o     (buf_slice_s),
        .data_o      (buf_data_s)
    );

    assign any_mem_s   = ld | st | ldb | stb;
    assign in_burst_s  = (state_q == BURST_RD) | (state_q == BURST_WR);
    assign last_beat_s = (beat_q == 7'(BM_WORDS - 1));
    assign done_s      = mem_ack & ((state_q == WORD) | (in_burst_s & last_beat_s));

    // Memory port is decoded from registered state, so reset drops mem_req at once.
    assign mem_req   = (state_q != IDLE);
    assign mem_we    = ((state_q == WORD) & word_st_q) | (state_q == BURST_WR);
    assign mem_addr  = beat_addr(addr_q, beat_q);
    assign mem_wdata = (state_q == BURST_WR) ? buf_slice_s : st_data_q;
    assign stall     = (mem_req & ~done_s) | ((state_q == IDLE) & in_valid & any_mem_s);

    assign wb_valid   = wb_valid_q;
    assign wb_rd_we   = wb_rd_we_q;
    assign wb_bd_we   = wb_bd_we_q;
    assign wb_rd_addr = wb_rd_addr_q;
    assign wb_bd_addr = wb_bd_addr_q;
    assign wb_rd_data = wb_rd_data_q;
    assign wb_bd_data = wb_bd_data_q;

    // Next-state, operand latching and writeback bundle.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        addr_d       = addr_q;
        st_data_d    = st_data_q;
        rd_addr_d    = rd_addr_q;
        bd_addr_d    = bd_addr_q;
        word_st_d    = word_st_q;
        wb_valid_d   = 1'b0;
        wb_rd_we_d   = wb_rd_we_q;
        wb_bd_we_d   = wb_bd_we_q;
        wb_rd_addr_d = wb_rd_addr_q;
        wb_bd_addr_d = wb_bd_addr_q;
        wb_rd_data_d = wb_rd_data_q;
        wb_bd_data_d = wb_bd_data_q;
        buf_load_s   = 1'b0;
        buf_wr_s     = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (ldb || stb) begin
                        state_d    = ldb ? BURST_RD : BURST_WR;
                        beat_d     = 7'd0;
                        addr_d     = rd_data;
                        bd_addr_d  = bd_addr;
                        buf_load_s = 1'b1;
                    end else if (ld || st) begin
                        state_d   = WORD;
                        word_st_d = ~ld;
                        addr_d    = rd_data;
                        st_data_d = st_data;
                        rd_addr_d = rd_addr;
                    end else begin
                        wb_valid_d   = 1'b1;
                        wb_rd_we_d   = rd_we;
                        wb_bd_we_d   = bd_we;
                        wb_rd_addr_d = rd_addr;
                        wb_bd_addr_d = bd_addr;
                        wb_rd_data_d = rd_data;
                        wb_bd_data_d = bd_data;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WORD: begin
                if (mem_ack) begin
                    state_d      = IDLE;
                    wb_valid_d   = 1'b1;
                    wb_rd_we_d   = ~word_st_q;
                    wb_bd_we_d   = 1'b0;
                    wb_rd_addr_d = rd_addr_q;
                    if (!word_st_q) begin
                        wb_rd_data_d = mem_rdata;
                    end else begin
                        wb_rd_data_d = wb_rd_data_q;
                    end
                end else begin
                    state_d = WORD;
                end
            end
            BURST_RD, BURST_WR: begin
                buf_wr_s = (state_q == BURST_RD) & mem_ack;
                if (mem_ack) begin
                    if (last_beat_s) begin
                        state_d      = IDLE;
                        beat_d       = 7'd0;
                        wb_valid_d   = 1'b1;
                        wb_rd_we_d   = 1'b0;
                        wb_bd_we_d   = (state_q == BURST_RD);
                        wb_bd_addr_d = bd_addr_q;
                        // The final beat is still in flight, so merge it on the way out.
                        if (state_q == BURST_RD) begin
                            wb_bd_data_d = {mem_rdata, buf_data_s[BM_W-WORD_W-1:0]};
                        end else begin
                            wb_bd_data_d = buf_data_s;
                        end
                    end else begin
                        beat_d = beat_q + 7'd1;
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and operand registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= 7'd0;
            addr_q    <= 16'd0;
            st_data_q <= 16'd0;
            rd_addr_q <= 4'd0;
            bd_addr_q <= 2'd0;
            word_st_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            addr_q    <= addr_d;
            st_data_q <= st_data_d;
            rd_addr_q <= rd_addr_d;
            bd_addr_q <= bd_addr_d;
            word_st_q <= word_st_d;
        end
    end

    // Writeback registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q   <= 1'b0;
            wb_rd_we_q   <= 1'b0;
            wb_bd_we_q   <= 1'b0;
            wb_rd_addr_q <= 4'd0;
            wb_bd_addr_q <= 2'd0;
            wb_rd_data_q <= 16'd0;
            wb_bd_data_q <= '0;
        end else begin
            wb_valid_q   <= wb_valid_d;
            wb_rd_we_q   <= wb_rd_we_d;
            wb_bd_we_q   <= wb_bd_we_d;
            wb_rd_addr_q <= wb_rd_addr_d;
            wb_bd_addr_q <= wb_bd_addr_d;
            wb_rd_data_q <= wb_rd_data_d;
            wb_bd_data_q <= wb_bd_data_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a memory responder model and a writeback monitor
// check the DUT against expectations computed from the op semantics.
module tb_mem_stage;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, ld = 1'b0, st = 1'b0, ldb = 1'b0, stb = 1'b0;
    logic [15:0]   rd_data = 16'd0, st_data = 16'd0;
    logic [1535:0] bd_data = '0;
    logic [3:0]    rd_addr = 4'd0;
    logic [1:0]    bd_addr = 2'd0;
    logic          rd_we = 1'b0, bd_we = 1'b0;
    logic          stall, mem_req, mem_we;
    logic [15:0]   mem_addr, mem_wdata;
    logic [15:0]   mem_rdata = 16'd0;
    logic          mem_ack = 1'b0;
    logic          wb_valid, wb_rd_we, wb_bd_we;
    logic [3:0]    wb_rd_addr;
    logic [1:0]    wb_bd_addr;
    logic [15:0]   wb_rd_data;
    logic [1535:0] wb_bd_data;

    mem_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ld(ld), .st(st), .ldb(ldb), .stb(stb),
        .rd_data(rd_data), .st_data(st_data), .bd_data(bd_data), .rd_addr(rd_addr),
        .bd_addr(bd_addr), .rd_we(rd_we), .bd_we(bd_we), .stall(stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .wb_valid(wb_valid), .wb_rd_we(wb_rd_we), .wb_bd_we(wb_bd_we),
        .wb_rd_addr(wb_rd_addr), .wb_bd_addr(wb_bd_addr), .wb_rd_data(wb_rd_data),
        .wb_bd_data(wb_bd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rd_we, bd_we, chk_rd, chk_bd;
        logic [3:0]    rd_addr;
        logic [1:0]    bd_addr;
        logic [15:0]   rd_data;
        logic [1535:0] bd_data;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [15:0] addr, data;
    } acc_t;

    wb_exp_t     exp_q[$];
    acc_t        acc_q[$];
    logic [15:0] mem_m[logic [15:0]];
    int          vectors = 0, fails = 0;
    int          fixed_gap = 0, max_gap = 3;
    int          req_cycles = 0, ack_count = 0;

    task automatic chk(input string name, input logic [1535:0] act, input logic [1535:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a ^ 16'h5555;
    endfunction

    function automatic int pick_gap();
        if (fixed_gap >= 0) return fixed_gap;
        return $urandom_range(max_gap, 0);
    endfunction

    // Memory responder: random ack gaps, address/data stability while waiting.
    bit          pending = 1'b0;
    int          gap_cnt = 0;
    logic [15:0] hold_addr, hold_wdata;
    logic        hold_we;
    always @(negedge clk) begin
        acc_t a;
        mem_ack = 1'b0;
        if (rst) begin
            pending = 1'b0;
        end else if (mem_req) begin
            req_cycles++;
            if (!pending) begin
                pending = 1'b1;
                gap_cnt = pick_gap();
                hold_addr = mem_addr; hold_we = mem_we; hold_wdata = mem_wdata;
            end else begin
                chk("addr_stable", mem_addr, hold_addr);
                chk("we_stable", mem_we, hold_we);
                if (hold_we) chk("wdata_stable", mem_wdata, hold_wdata);
            end
            if (gap_cnt == 0) begin
                mem_ack = 1'b1;
                pending = 1'b0;
                ack_count++;
                if (acc_q.size() == 0) begin
                    chk("unexpected_access", 1'b1, 1'b0);
                end else begin
                    a = acc_q.pop_front();
                    chk("mem_we", mem_we, a.we);
                    chk("mem_addr", mem_addr, a.addr);
                    if (a.we) chk("mem_wdata", mem_wdata, a.data);
                end
                if (mem_we) mem_m[mem_addr] = mem_wdata;
                else mem_rdata = model_rd(mem_addr);
            end else begin
                gap_cnt--;
            end
        end
    end

    // Writeback monitor.
    always @(negedge clk) begin
        wb_exp_t e;
        if (!rst && wb_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wb_valid", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("wb_rd_we", wb_rd_we, e.rd_we);
                chk("wb_bd_we", wb_bd_we, e.bd_we);
                if (e.chk_rd) begin
                    chk("wb_rd_data", wb_rd_data, e.rd_data);
                    chk("wb_rd_addr", wb_rd_addr, e.rd_addr);
                end
                if (e.chk_bd) begin
                    chk("wb_bd_data", wb_bd_data, e.bd_data);
                    chk("wb_bd_addr", wb_bd_addr, e.bd_addr);
                end
            end
        end
    end

    // Expected accesses for a 96-beat burst.
    task automatic push_burst(input logic we, input logic [15:0] base, input logic [1535:0] bd);
        acc_t a;
        for (int i = 0; i < 96; i++) begin
            a.we   = we;
            a.addr = base + 16'(i);
            a.data = bd[i*16 +: 16];
            acc_q.push_back(a);
        end
    endtask

    // flags = {ldb, stb, ld, st}
    task automatic issue(input logic [3:0] flags, input logic [15:0] a, input logic [15:0] sd,
                         input logic [1535:0] bd, input logic [3:0] ra, input logic [1:0] ba,
                         input logic rwe, input logic bwe);
        wb_exp_t e;
        acc_t    w;
        int      n;
        e = '{rd_we: 1'b0, bd_we: 1'b0, chk_rd: 1'b0, chk_bd: 1'b0, rd_addr: ra,
              bd_addr: ba, rd_data: 16'd0, bd_data: '0};
        if (flags[3]) begin
            e.bd_we = 1'b1; e.chk_bd = 1'b1;
            for (int i = 0; i < 96; i++) e.bd_data[i*16 +: 16] = model_rd(a + 16'(i));
            push_burst(1'b0, a, bd);
        end else if (flags[2]) begin
            push_burst(1'b1, a, bd);
        end else if (flags[1]) begin
            e.rd_we = 1'b1; e.chk_rd = 1'b1; e.rd_data = model_rd(a);
            w = '{we: 1'b0, addr: a, data: 16'd0};
            acc_q.push_back(w);
        end else if (flags[0]) begin
            w = '{we: 1'b1, addr: a, data: sd};
            acc_q.push_back(w);
        end else begin
            e.rd_we = rwe; e.bd_we = bwe; e.chk_rd = 1'b1; e.chk_bd = 1'b1;
            e.rd_data = a; e.bd_data = bd;
        end
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b1; {ldb, stb, ld, st} = flags;
        rd_data = a; st_data = sd; bd_data = bd; rd_addr = ra; bd_addr = ba;
        rd_we = rwe; bd_we = bwe;
        #1;
        chk("stall_on_accept", stall, (flags != 4'd0));
        n = 0;
        while (stall && n < 3000) begin
            @(negedge clk); #1; n++;
        end
        if (stall) chk("stall_timeout", 1'b1, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0; {ldb, stb, ld, st} = 4'd0;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [1535:0] rand_bm();
        logic [1535:0] v;
        for (int k = 0; k < 48; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1535:0] ramp;
        int            r0, n;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'd0);
        chk("rst_mem_wdata", mem_wdata, 16'd0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_rd_we", wb_rd_we, 1'b0);
        chk("rst_wb_bd_we", wb_bd_we, 1'b0);
        chk("rst_wb_rd_data", wb_rd_data, 16'd0);
        chk("rst_wb_rd_addr", wb_rd_addr, 4'd0);
        chk("rst_wb_bd_addr", wb_bd_addr, 2'd0);
        chk("rst_wb_bd_data", wb_bd_data, 1536'd0);
        chk("rst_stall", stall, 1'b0);
        @(posedge clk); #2 rst = 1'b0;

        // Directed cases.
        issue(4'b0000, 16'h1234, 16'h0, rand_bm(), 4'd5, 2'd1, 1'b1, 1'b0);
        fixed_gap = 3;
        mem_m[16'h0040] = 16'hBEEF;
        issue(4'b0010, 16'h0040, 16'h0, '0, 4'd7, 2'd0, 1'b0, 1'b0);
        fixed_gap = 0;
        issue(4'b0001, 16'h0100, 16'hA5A5, '0, 4'd2, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 96; i++) ramp[i*16 +: 16] = 16'(i);
        r0 = req_cycles;
        issue(4'b0100, 16'hFFF0, 16'h0, ramp, 4'd0, 2'd3, 1'b0, 1'b0);
        chk("burst_req_cycles", 32'(req_cycles - r0), 32'd96);
        fixed_gap = -1;
        issue(4'b1000, 16'h2000, 16'h0, rand_bm(), 4'd0, 2'd2, 1'b0, 1'b0);

        // Reset in the middle of a bitmap load.
        r0 = ack_count;
        push_burst(1'b0, 16'h3000, '0);
        @(negedge clk);
        in_valid = 1'b1; ldb = 1'b1; rd_data = 16'h3000; bd_addr = 2'd1;
        n = 0;
        while (ack_count < r0 + 40 && n < 1000) begin
            @(negedge clk); n++;
        end
        chk("beat40_reached", (ack_count >= r0 + 40), 1'b1);
        @(posedge clk); #2 rst = 1'b1;
        #1 chk("rst_mid_mem_req", mem_req, 1'b0);
        in_valid = 1'b0; ldb = 1'b0;
        #1 chk("rst_mid_idle", stall, 1'b0);
        acc_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        issue(4'b0010, 16'h0777, 16'h0, '0, 4'd9, 2'd0, 1'b0, 1'b0);

        // Randomized mix, including multi-flag priority cases.
        for (int t = 0; t < 30; t++) begin
            issue(4'($urandom_range(15, 0)), 16'($urandom()), 16'($urandom()), rand_bm(),
                  4'($urandom()), 2'($urandom()), 1'($urandom()), 1'($urandom()));
        end

        repeat (5) @(negedge clk);
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("acc_queue_drained", 32'(acc_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
